imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 118 +++++++++++
 tb/tb_imem_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: parses a framed host byte stream
// (length, little-endian data words, XOR checksum) and writes words into imem.
module imem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_hold,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

  state_t      state, state_next;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] word_cnt;
  logic [1:0]  byte_cnt;
  logic [23:0] word_buf;
  logic [7:0]  xor_acc;
  logic        accept;
  logic        last_word;
  logic        do_reload;
  logic [16:0] len_in;

  assign byte_ready = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
  assign done       = (state == DONE);
  assign error      = (state == ERR);
  assign core_hold  = (state != DONE);
  assign accept     = byte_valid && byte_ready;
  assign last_word  = (word_cnt == len - 16'd1);
  assign do_reload  = reload && ((state == DONE) || (state == ERR));
  assign len_in     = {1'b0, byte_data, len_lo};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LEN0;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LEN0: if (accept) state_next = LEN1;
      LEN1: begin
        if (accept) begin
          if (len_in > MAX_WORDS) state_next = ERR;
          else if (len_in == 17'd0) state_next = CSUM;
          else state_next = DATA;
        end
      end
      DATA: if (accept && byte_cnt == 2'd3 && last_word) state_next = CSUM;
      CSUM: if (accept) state_next = (byte_data == xor_acc) ? DONE : ERR;
      DONE, ERR: if (reload) state_next = LEN0;
      default: state_next = LEN0;
    endcase
  end

  // The first three bytes of a word shift down so the 4th byte lands on top.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_lo     <= '0;
      len        <= '0;
      word_cnt   <= '0;
      byte_cnt   <= '0;
      word_buf   <= '0;
      xor_acc    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      if (do_reload) begin
        len_lo   <= '0;
        len      <= '0;
        word_cnt <= '0;
        byte_cnt <= '0;
        word_buf <= '0;
        xor_acc  <= '0;
      end else if (accept) begin
        case (state)
          LEN0: begin
            len_lo  <= byte_data;
            xor_acc <= xor_acc ^ byte_data;
          end
          LEN1: begin
            len     <= {byte_data, len_lo};
            xor_acc <= xor_acc ^ byte_data;
          end
          DATA: begin
            xor_acc <= xor_acc ^ byte_data;
            if (byte_cnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_cnt[ADDR_WIDTH-1:0];
              imem_wdata <= {byte_data, word_buf};
              word_cnt   <= word_cnt + 16'd1;
              byte_cnt   <= 2'd0;
            end else begin
              word_buf <= {byte_data, word_buf[23:8]};
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: frame loads, checksum and
// length errors, reload handling, full-memory fill and mid-frame reset.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        reload;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_hold;
  logic        done;
  logic        error;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  frame[$];
  int          wr_total = 0;
  logic [9:0]  wr_addr[2048];
  logic [31:0] wr_data[2048];

  imem_loader #(.ADDR_WIDTH(10)) dut (
    .clk(clk),
    .rst(rst),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .reload(reload),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .core_hold(core_hold),
    .done(done),
    .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every strobe-high cycle is logged once, so a stretched strobe shows up as extra writes.
  always @(negedge clk) begin
    if (imem_we) begin
      if (wr_total < 2048) begin
        wr_addr[wr_total] = imem_addr;
        wr_data[wr_total] = imem_wdata;
      end
      wr_total = wr_total + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int gap_max);
    int gaps;
    gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    byte_valid = 1'b0;
    repeat (gaps) begin
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic sendFrame(input int gap_max);
    foreach (frame[i]) applyStimulus(frame[i], gap_max);
  endtask

  task automatic pulseReload();
    byte_valid = 1'b0;
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  initial begin
    int base;
    int bad_words;
    logic [7:0] csum;
    logic [15:0] idx;

    rst = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    reload = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_hold_core_hold", core_hold, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_byte_ready", byte_ready, 1'b1);
    checkOutput("rst_core_hold", core_hold, 1'b1);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_error", error, 1'b0);
    checkOutput("rst_imem_we", imem_we, 1'b0);
    checkOutput("rst_imem_addr", imem_addr, 32'd0);
    checkOutput("rst_imem_wdata", imem_wdata, 32'd0);

    // Two-word load, back to back
    base = wr_total;
    frame = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
    sendFrame(0);
    @(negedge clk);
    checkOutput("two_write_count", wr_total - base, 2);
    checkOutput("two_addr0", wr_addr[base], 32'd0);
    checkOutput("two_data0", wr_data[base], 32'h00000013);
    checkOutput("two_addr1", wr_addr[base+1], 32'd1);
    checkOutput("two_data1", wr_data[base+1], 32'h00100093);
    checkOutput("two_done", done, 1'b1);
    checkOutput("two_core_hold", core_hold, 1'b0);
    checkOutput("two_byte_ready", byte_ready, 1'b0);
    checkOutput("two_error", error, 1'b0);
    checkOutput("two_addr_held", imem_addr, 32'd1);

    // Bad checksum after reload
    pulseReload();
    @(negedge clk);
    checkOutput("reload1_done", done, 1'b0);
    checkOutput("reload1_core_hold", core_hold, 1'b1);
    checkOutput("reload1_byte_ready", byte_ready, 1'b1);
    base = wr_total;
    frame = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
    sendFrame(0);
    @(negedge clk);
    checkOutput("badcs_write_count", wr_total - base, 2);
    checkOutput("badcs_data1", wr_data[base+1], 32'h00100093);
    checkOutput("badcs_error", error, 1'b1);
    checkOutput("badcs_core_hold", core_hold, 1'b1);
    checkOutput("badcs_done", done, 1'b0);
    checkOutput("badcs_byte_ready", byte_ready, 1'b0);

    // Length overflow, N = 1025
    pulseReload();
    @(negedge clk);
    checkOutput("reload2_error", error, 1'b0);
    base = wr_total;
    frame = '{8'h01, 8'h04};
    sendFrame(0);
    @(negedge clk);
    checkOutput("ovf_error", error, 1'b1);
    checkOutput("ovf_byte_ready", byte_ready, 1'b0);
    checkOutput("ovf_no_write", wr_total - base, 0);
    checkOutput("ovf_core_hold", core_hold, 1'b1);

    // Empty frame
    pulseReload();
    base = wr_total;
    frame = '{8'h00, 8'h00, 8'h00};
    sendFrame(0);
    @(negedge clk);
    checkOutput("empty_done", done, 1'b1);
    checkOutput("empty_no_write", wr_total - base, 0);
    pulseReload();
    @(negedge clk);
    checkOutput("reload3_done", done, 1'b0);
    checkOutput("reload3_core_hold", core_hold, 1'b1);
    checkOutput("reload3_byte_ready", byte_ready, 1'b1);

    // One word with gaps and a reload mid-frame that must be ignored.
    // Checksum 01^00^EF^BE^AD^DE = 23.
    base = wr_total;
    frame = '{8'h01, 8'h00, 8'hEF, 8'hBE};
    sendFrame(3);
    pulseReload();
    @(negedge clk);
    checkOutput("ignored_reload_ready", byte_ready, 1'b1);
    frame = '{8'hAD, 8'hDE, 8'h23};
    sendFrame(3);
    @(negedge clk);
    checkOutput("gap_write_count", wr_total - base, 1);
    checkOutput("gap_addr0", wr_addr[base], 32'd0);
    checkOutput("gap_data0", wr_data[base], 32'hDEADBEEF);
    checkOutput("gap_done", done, 1'b1);

    // Full memory fill, N = 1024
    pulseReload();
    base = wr_total;
    frame = {};
    frame.push_back(8'h00);
    frame.push_back(8'h04);
    csum = 8'h04;
    for (int i = 0; i < 1024; i++) begin
      idx = 16'(i);
      frame.push_back(idx[7:0]);
      frame.push_back(idx[15:8]);
      frame.push_back(8'h5A);
      frame.push_back(8'hC3);
      csum = csum ^ idx[7:0] ^ idx[15:8] ^ 8'h5A ^ 8'hC3;
    end
    frame.push_back(csum);
    sendFrame(0);
    @(negedge clk);
    checkOutput("fill_write_count", wr_total - base, 1024);
    bad_words = 0;
    for (int i = 0; i < 1024; i++) begin
      idx = 16'(i);
      if (wr_addr[base+i] !== idx[9:0] || wr_data[base+i] !== {8'hC3, 8'h5A, idx[15:8], idx[7:0]})
        bad_words++;
    end
    checkOutput("fill_bad_words", bad_words, 0);
    checkOutput("fill_last_addr", wr_addr[base+1023], 32'd1023);
    checkOutput("fill_done", done, 1'b1);

    // Reset in the middle of DATA
    pulseReload();
    frame = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    sendFrame(0);
    rst = 1'b0;
    #1;
    checkOutput("midrst_byte_ready", byte_ready, 1'b1);
    checkOutput("midrst_core_hold", core_hold, 1'b1);
    checkOutput("midrst_imem_we", imem_we, 1'b0);
    checkOutput("midrst_imem_addr", imem_addr, 32'd0);
    checkOutput("midrst_imem_wdata", imem_wdata, 32'd0);
    checkOutput("midrst_done", done, 1'b0);
    checkOutput("midrst_error", error, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    // Checksum 01^00^78^56^34^12 = 09
    base = wr_total;
    frame = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
    sendFrame(0);
    @(negedge clk);
    checkOutput("after_rst_write_count", wr_total - base, 1);
    checkOutput("after_rst_addr0", wr_addr[base], 32'd0);
    checkOutput("after_rst_data0", wr_data[base], 32'h12345678);
    checkOutput("after_rst_done", done, 1'b1);
    checkOutput("after_rst_core_hold", core_hold, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
